// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_SEG   = 4;

    // Number of pipeline stages; 0 flags an illegal SEG so the top can report it.
    function automatic int unsigned calc_stages(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 0 : width / seg;
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple segment: {co, s} = a + b + ci.
module adder_seg
    import adder_pkg::*;
#(
    parameter int unsigned SEG = DEFAULT_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder, SEG bits per stage, valid/ready flow control with a global stall.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output ovf.
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
`ifdef ADDER_PIPE_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned STAGES = calc_stages(WIDTH, SEG);
    localparam int unsigned LAST   = STAGES - 1;

    if (SEG < 1) begin : gen_bad_seg
        $error("adder_pipe_nbit: SEG must be at least 1");
    end else if (WIDTH % SEG != 0) begin : gen_bad_split
        $error("adder_pipe_nbit: WIDTH must be a multiple of SEG");
    end
    if (WIDTH < 4) begin : gen_bad_width
        $error("adder_pipe_nbit: WIDTH must be at least 4");
    end

    // Per-stage registers: operands ride along in full so ovf can see their MSBs at the end.
    logic             v_q [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];

    logic [SEG-1:0]   seg_a   [STAGES];
    logic [SEG-1:0]   seg_b   [STAGES];
    logic [SEG-1:0]   seg_s   [STAGES];
    logic             seg_ci  [STAGES];
    logic             seg_co  [STAGES];
    logic [WIDTH-1:0] sum_nxt [STAGES];

    logic en;

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        if (k == 0) begin : gen_head
            assign seg_a[k]   = a[SEG-1:0];
            assign seg_b[k]   = b[SEG-1:0];
            assign seg_ci[k]  = ci;
            assign sum_nxt[k] = WIDTH'(seg_s[k]);
        end else begin : gen_body
            localparam int unsigned LO = k * SEG;
            assign seg_a[k]  = a_q[k-1][LO +: SEG];
            assign seg_b[k]  = b_q[k-1][LO +: SEG];
            assign seg_ci[k] = c_q[k-1];
            // Bits above the finished segments are always zero, so OR merges cleanly.
            assign sum_nxt[k] = s_q[k-1] | (WIDTH'(seg_s[k]) << LO);
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a  (seg_a[k]),
            .b  (seg_b[k]),
            .ci (seg_ci[k]),
            .s  (seg_s[k]),
            .co (seg_co[k])
        );
    end

    assign en       = !v_q[LAST] || out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (en) begin
            v_q[0] <= in_valid;
            a_q[0] <= a;
            b_q[0] <= b;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                s_q[k] <= sum_nxt[k];
                c_q[k] <= seg_co[k];
            end
        end
    end

    assign out_valid = v_q[LAST];
    assign s         = s_q[LAST];
    assign co        = c_q[LAST];

`ifdef ADDER_PIPE_OVF_EN
    assign ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                 (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`endif

endmodule

// File: doc/adder_pipe_nbit.md
ADDER_PIPE_NBIT -- requirements
Module: adder_pipe_nbit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits (>=4).
REQ-002 SHALL have parameter SEG, default 4, bits added per pipeline stage; WIDTH%SEG==0, STAGES=WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port ci  input  1  carry-in.
REQ-008 SHALL have port in_valid  input  1  a/b/ci valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-010 SHALL have port s  output  WIDTH  sum.
REQ-011 SHALL have port co  output  1  carry-out.
REQ-012 SHALL have port out_valid  output  1  s/co valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-014 SHALL compute {co,s} = a + b + ci, exactly WIDTH+1 bits, unsigned, no truncation other than to WIDTH+1.
REQ-015 SHALL split addition into STAGES segments; stage k adds bits [k*SEG +: SEG] plus carry registered from stage k-1; stage 0 uses ci.
REQ-016 SHALL carry not-yet-added upper operand bits and already-computed lower sum bits forward in skew registers alongside each stage.
REQ-017 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-018 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en (combinational from out_ready and state only, not from in_valid).
REQ-019 When en=1 every stage register and its valid bit SHALL shift one stage; when en=0 all stages SHALL hold.
REQ-020 Latency SHALL be exactly STAGES cycles from accepting transfer to out_valid when out_ready stays 1.
REQ-021 Throughput SHALL be one result per cycle with continuous in_valid and out_ready.
REQ-022 Bubbles (in_valid=0 while en=1) SHALL propagate as invalid stages; out_valid low for them.
REQ-023 s/co SHALL remain stable while out_valid && !out_ready.
REQ-024 Results SHALL emerge in acceptance order; no drop, no duplication, under any out_ready pattern.
REQ-025 SEG==WIDTH SHALL degenerate to single-stage registered adder, latency 1.

Reset
REQ-026 On rst=1 at clk edge all stage valid bits SHALL clear; out_valid=0, s=0, co=0 next cycle.
REQ-027 rst SHALL take priority over any simultaneous transfer; in-flight operands SHALL be discarded.
REQ-028 in_ready SHALL be 1 during and immediately after reset (pipeline empty).

Configuration
REQ-029 Macro ADDER_PIPE_OVF_EN defined: SHALL add output port ovf  output  1  two's-complement signed overflow (a[MSB]==b[MSB] && s[MSB]!=a[MSB]), aligned and stalled with s, reset 0.
REQ-030 Macro absent: port ovf and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-031 Shared package adder_pkg SHALL hold default WIDTH/SEG constants and a STAGES-computing function.
REQ-032 SHALL instantiate sub-module adder_seg (combinational SEG-bit add: a,b,ci -> s,co) once per stage via generate.
REQ-033 Parameter legality (WIDTH%SEG!=0, SEG<1) SHALL be flagged at elaboration.

Verification
REQ-034 WIDTH=16,SEG=4: a=0xFFFF,b=0x0001,ci=0 accepted cycle 0 -> out_valid cycle 4, s=0x0000, co=1.
REQ-035 WIDTH=4,SEG=4: all 512 a/b/ci combinations back-to-back -> each result next cycle, matches a+b+ci, in order.
REQ-036 WIDTH=16,SEG=4: 8 consecutive transfers, out_ready held 0 cycles 5-9 -> in_ready=0 cycles 5-9, s/co frozen, all 8 results delivered in order, none lost.
REQ-037 Random in_valid/out_ready 10k transfers vs reference model -> zero mismatches, count in == count out.
REQ-038 rst asserted with 3 ops in flight -> out_valid=0, s=0, co=0 next cycle; no stale result emerges afterward.
REQ-039 ADDER_PIPE_OVF_EN defined: 0x7FFF+0x0001 -> ovf=1, s=0x8000, co=0; 0xFFFF+0x0001 -> ovf=0.
